// File: rtl/mdu_iter_if.sv
// Operand/result bundle between the EX stage and the iterative multiply/divide unit.
// The master side issues operations; the slave side (the MDU) returns status and HI/LO.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO registers.
// Operations run on magnitudes in CALC; sign correction and the HI/LO commit happen in FIX.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic       clk,
    input  logic       reset,
    mdu_iter_if.slave  bus
);
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W  = {WIDTH{1'b1}};
    localparam logic [CNTW-1:0]    ZERO_C  = {CNTW{1'b0}};
    localparam logic [CNTW-1:0]    ONE_C   = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0]    LAST_C  = CNTW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;     // product high half / partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;     // multiplier bits / dividend-then-quotient
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             neg_rem_q, neg_rem_d;
    logic             b_zero_q, b_zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             signed_op_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [WIDTH:0]   mul_add_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH+1:0] div_diff_s;
    logic             div_ok_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0] rem_fix_s;
    logic [WIDTH-1:0] quo_fix_s;

    assign signed_op_s = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign a_neg_s     = signed_op_s & bus.a[WIDTH-1];
    assign b_neg_s     = signed_op_s & bus.b[WIDTH-1];
    assign mag_a_s     = a_neg_s ? (~bus.a + ONE_W) : bus.a;
    assign mag_b_s     = b_neg_s ? (~bus.b + ONE_W) : bus.b;

    assign mul_add_s   = quo_q[0] ? {1'b0, mag_b_q} : {(WIDTH+1){1'b0}};
    assign mul_sum_s   = {1'b0, rem_q} + mul_add_s;

    // Trial subtract succeeds when the difference is non-negative (and so fits WIDTH bits).
    assign div_shift_s = {rem_q, quo_q[WIDTH-1]};
    assign div_diff_s  = {1'b0, div_shift_s} - {2'b00, mag_b_q};
    assign div_ok_s    = (div_diff_s[WIDTH+1:WIDTH] == 2'b00);

    assign prod_s      = {rem_q, quo_q};
    assign prod_fix_s  = neg_q ? (~prod_s + ONE_2W) : prod_s;
    assign rem_fix_s   = neg_rem_q ? (~rem_q + ONE_W) : rem_q;
    assign quo_fix_s   = b_zero_q ? ONES_W : (neg_q ? (~quo_q + ONE_W) : quo_q);

    // Next-state, datapath step and HI/LO update logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        mag_b_d   = mag_b_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (bus.start) begin
                    case (bus.op)
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d   = ST_CALC;
                            busy_d    = 1'b1;
                            cnt_d     = ZERO_C;
                            rem_d     = ZERO_W;
                            quo_d     = mag_a_s;
                            mag_b_d   = mag_b_s;
                            is_div_d  = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
                            neg_d     = a_neg_s ^ b_neg_s;
                            neg_rem_d = a_neg_s;
                            b_zero_d  = (bus.b == ZERO_W);
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                    if (is_div_q) begin
                        rem_d = div_ok_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], div_ok_s};
                    end else begin
                        rem_d = mul_sum_s[WIDTH:1];
                        quo_d = {mul_sum_s[0], quo_q[WIDTH-1:1]};
                    end
                    if (cnt_q == LAST_C) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (bus.flush) begin
                    done_d = 1'b0;
                end else if (is_div_q) begin
                    hi_d   = rem_fix_s;
                    lo_d   = quo_fix_s;
                    done_d = 1'b1;
                end else begin
                    hi_d   = prod_fix_s[2*WIDTH-1:WIDTH];
                    lo_d   = prod_fix_s[WIDTH-1:0];
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, working registers and architectural HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= ZERO_C;
            rem_q     <= ZERO_W;
            quo_q     <= ZERO_W;
            mag_b_q   <= ZERO_W;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= ZERO_W;
            lo_q      <= ZERO_W;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            mag_b_q   <= mag_b_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Randomized and directed bench for mdu_iter against a plain-arithmetic HI/LO model.
module tb_mdu_iter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;

    mdu_iter_if #(.WIDTH(32)) bus_if ();

    mdu_iter #(.WIDTH(32), .CNTW(6)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Architectural result of one operation, from ordinary integer arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        eh = mdl_hi;
        el = mdl_lo;
        case (o)
            3'd1: begin p = sx * sy; eh = p[63:32]; el = p[31:0]; end
            3'd2: begin p = {32'd0, x} * {32'd0, y}; eh = p[63:32]; el = p[31:0]; end
            3'd3: begin
                if (y == 32'd0) begin
                    eh = x; el = 32'hFFFF_FFFF;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    eh = 32'd0; el = 32'h8000_0000;
                end else begin
                    q = sx / sy; r = sx % sy;
                    eh = r[31:0]; el = q[31:0];
                end
            end
            3'd4: begin
                if (y == 32'd0) begin
                    eh = x; el = 32'hFFFF_FFFF;
                end else begin
                    eh = x % y; el = x / y;
                end
            end
            3'd5: eh = x;
            3'd6: el = x;
            default: begin end
        endcase
    endtask

    task automatic run_mt(input logic [2:0] o, input logic [31:0] x);
        logic [31:0] eh, el;
        model(o, x, 32'd0, eh, el);
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op = o; bus_if.a = x; bus_if.b = 32'd0;
        @(negedge clk);
        bus_if.start = 1'b0; bus_if.op = 3'd0;
        check("mt_busy", {63'd0, bus_if.busy}, 64'd0);
        check("mt_done", {63'd0, bus_if.done}, 64'd0);
        check("mt_hi", {32'd0, bus_if.hi}, {32'd0, eh});
        check("mt_lo", {32'd0, bus_if.lo}, {32'd0, el});
        mdl_hi = eh;
        mdl_lo = el;
    endtask

    task automatic run_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit poke, input int flush_at);
        logic [31:0] eh, el, old_hi, old_lo;
        int busy_cnt, done_cnt, done_idx;
        old_hi = mdl_hi;
        old_lo = mdl_lo;
        model(o, x, y, eh, el);
        if (flush_at > 0) begin
            eh = old_hi;
            el = old_lo;
        end
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op = o; bus_if.a = x; bus_if.b = y;
        @(negedge clk);
        bus_if.start = 1'b0; bus_if.op = 3'd0;
        busy_cnt = 0; done_cnt = 0; done_idx = -1;
        for (int k = 0; k < 40; k++) begin
            if (bus_if.busy) busy_cnt++;
            if (bus_if.done) begin
                done_cnt++;
                done_idx = k;
            end
            if (k == 20) begin
                check("hold_hi", {32'd0, bus_if.hi}, {32'd0, old_hi});
                check("hold_lo", {32'd0, bus_if.lo}, {32'd0, old_lo});
            end
            bus_if.flush = (flush_at > 0) && (k == flush_at);
            if (poke && (k == 4 || k == 19)) begin
                bus_if.start = 1'b1; bus_if.op = 3'd1; bus_if.a = 32'd2; bus_if.b = 32'd3;
            end else begin
                bus_if.start = 1'b0; bus_if.op = 3'd0;
            end
            @(negedge clk);
        end
        bus_if.flush = 1'b0;
        check("busy_cycles", 64'(busy_cnt), 64'((flush_at > 0) ? flush_at + 1 : 33));
        check("done_pulses", 64'(done_cnt), 64'((flush_at > 0) ? 0 : 1));
        if (flush_at == 0) check("done_edge", 64'(done_idx), 64'd33);
        check("res_hi", {32'd0, bus_if.hi}, {32'd0, eh});
        check("res_lo", {32'd0, bus_if.lo}, {32'd0, el});
        mdl_hi = eh;
        mdl_lo = el;
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        total = 0; bad = 0;
        mdl_hi = 32'd0; mdl_lo = 32'd0;
        rst_n = 1'b0;
        bus_if.start = 1'b0; bus_if.op = 3'd0; bus_if.a = 32'd0; bus_if.b = 32'd0; bus_if.flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, bus_if.busy}, 64'd0);
        check("rst_hi", {32'd0, bus_if.hi}, 64'd0);
        rst_n = 1'b1;

        run_mt(3'd5, 32'hDEAD_BEEF);
        run_mt(3'd6, 32'h0BAD_F00D);
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op = 3'd1; bus_if.a = 32'd123; bus_if.b = 32'd456;
        @(negedge clk);
        bus_if.start = 1'b0; bus_if.op = 3'd0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'd0, bus_if.busy}, 64'd0);
        check("midrst_done", {63'd0, bus_if.done}, 64'd0);
        check("midrst_hi", {32'd0, bus_if.hi}, 64'd0);
        check("midrst_lo", {32'd0, bus_if.lo}, 64'd0);
        mdl_hi = 32'd0; mdl_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run_mt(3'd6, 32'h0000_1234);

        run_md(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 0);
        run_md(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_md(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        run_md(3'd4, 32'd100, 32'd7, 1'b0, 0);
        run_md(3'd4, 32'h64, 32'd0, 1'b0, 0);
        run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        run_md(3'd3, 32'hFFFF_FF00, 32'd0, 1'b0, 0);

        run_mt(3'd5, 32'hAAAA_0000);
        run_mt(3'd6, 32'h0000_5555);
        run_md(3'd1, 32'd7, 32'd9, 1'b0, 9);
        run_md(3'd2, 32'd7, 32'd9, 1'b0, 0);
        run_md(3'd4, 32'd100, 32'd7, 1'b1, 0);

        // flush together with start in IDLE: nothing is accepted
        @(negedge clk);
        bus_if.flush = 1'b1; bus_if.start = 1'b1; bus_if.op = 3'd5; bus_if.a = 32'h1111_1111;
        @(negedge clk);
        bus_if.op = 3'd1; bus_if.a = 32'd5; bus_if.b = 32'd6;
        @(negedge clk);
        bus_if.flush = 1'b0; bus_if.start = 1'b0; bus_if.op = 3'd0;
        check("iflush_busy", {63'd0, bus_if.busy}, 64'd0);
        check("iflush_hi", {32'd0, bus_if.hi}, {32'd0, mdl_hi});

        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            if ($urandom_range(0, 5) == 0) ry = 32'd0;
            else if ($urandom_range(0, 1) == 1) ry = $urandom;
            else ry = 32'($urandom_range(1, 20));
            if (ro >= 3'd1 && ro <= 3'd4) run_md(ro, rx, ry, 1'b0, 0);
            else run_mt(ro, rx);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
